// File: rtl/pingpong_stream_writer.sv
// ============================================================================
// pingpong_stream_writer : packs a valid/ready byte stream into alternating
// frames across two RAM banks with a full/release handoff to the reader.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pingpong_stream_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              ram1_write_en,
  output logic [ADDR_W-1:0] ram1_write_address,
  output logic [DATA_W-1:0] ram1_write_data,
  output logic              ram2_write_en,
  output logic [ADDR_W-1:0] ram2_write_address,
  output logic [DATA_W-1:0] ram2_write_data,
  output logic [1:0]        bank_full,
  output logic [ADDR_W:0]   bank_len0,
  output logic [ADDR_W:0]   bank_len1,
  input  logic [1:0]        bank_release,
  output logic              release_err
);

  typedef enum logic [0:0] {
    ST_WRITE = 1'b0,
    ST_WAIT  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [1:0]          full_q, full_d;
  logic [ADDR_W:0]     len0_q, len0_d;
  logic [ADDR_W:0]     len1_q, len1_d;
  logic                err_q, err_d;
  logic                wen1_q, wen1_d;
  logic [ADDR_W-1:0]   waddr1_q, waddr1_d;
  logic [DATA_W-1:0]   wdata1_q, wdata1_d;
  logic                wen2_q, wen2_d;
  logic [ADDR_W-1:0]   waddr2_q, waddr2_d;
  logic [DATA_W-1:0]   wdata2_q, wdata2_d;

  logic                accept;
  logic                close;
  logic [1:0]          full_rel;
  logic [ADDR_W:0]     frame_len;

  assign accept    = in_valid & ready_q;
  assign close     = accept & ((wr_addr_q == LAST_ADDR) | in_last);
  assign full_rel  = full_q & ~bank_release;
  assign frame_len = {1'b0, wr_addr_q} + (ADDR_W+1)'(1);

  always_comb begin
    state_d  = state_q;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    full_d   = full_rel;
    len0_d   = len0_q;
    len1_d   = len1_q;
    err_d    = err_q | (|(bank_release & ~full_q));
    wen1_d   = 1'b0;
    waddr1_d = waddr1_q;
    wdata1_d = wdata1_q;
    wen2_d   = 1'b0;
    waddr2_d = waddr2_q;
    wdata2_d = wdata2_q;

    if (accept) begin
      if (!wr_bank_q) begin
        wen1_d   = 1'b1;
        waddr1_d = wr_addr_q;
        wdata1_d = in_data;
      end else begin
        wen2_d   = 1'b1;
        waddr2_d = wr_addr_q;
        wdata2_d = in_data;
      end
    end

    if (close) begin
      full_d[wr_bank_q] = 1'b1;
      if (!wr_bank_q) len0_d = frame_len;
      else            len1_d = frame_len;
      wr_addr_d = '0;
      wr_bank_d = ~wr_bank_q;
    end else if (accept) begin
      wr_addr_d = wr_addr_q + ADDR_W'(1);
    end

    // Stall only if the bank we are about to fill is still held by the reader.
    case (state_q)
      ST_WRITE: if (close && full_rel[~wr_bank_q]) state_d = ST_WAIT;
      ST_WAIT:  if (bank_release[wr_bank_q])       state_d = ST_WRITE;
      default:  state_d = ST_WRITE;
    endcase

    ready_d = (state_d == ST_WRITE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_WRITE;
      ready_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      full_q    <= '0;
      len0_q    <= '0;
      len1_q    <= '0;
      err_q     <= 1'b0;
      wen1_q    <= 1'b0;
      waddr1_q  <= '0;
      wdata1_q  <= '0;
      wen2_q    <= 1'b0;
      waddr2_q  <= '0;
      wdata2_q  <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      full_q    <= full_d;
      len0_q    <= len0_d;
      len1_q    <= len1_d;
      err_q     <= err_d;
      wen1_q    <= wen1_d;
      waddr1_q  <= waddr1_d;
      wdata1_q  <= wdata1_d;
      wen2_q    <= wen2_d;
      waddr2_q  <= waddr2_d;
      wdata2_q  <= wdata2_d;
    end
  end

  assign in_ready           = ready_q;
  assign ram1_write_en      = wen1_q;
  assign ram1_write_address = waddr1_q;
  assign ram1_write_data    = wdata1_q;
  assign ram2_write_en      = wen2_q;
  assign ram2_write_address = waddr2_q;
  assign ram2_write_data    = wdata2_q;
  assign bank_full          = full_q;
  assign bank_len0          = len0_q;
  assign bank_len1          = len1_q;
  assign release_err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pingpong_stream_writer.sv
// ============================================================================
// tb_pingpong_stream_writer : directed + random stimulus against a frame-level
// behavioural model of the ping-pong writer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pingpong_stream_writer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       ram1_write_en;
  logic [4:0] ram1_write_address;
  logic [7:0] ram1_write_data;
  logic       ram2_write_en;
  logic [4:0] ram2_write_address;
  logic [7:0] ram2_write_data;
  logic [1:0] bank_full;
  logic [5:0] bank_len0;
  logic [5:0] bank_len1;
  logic [1:0] bank_release;
  logic       release_err;

  pingpong_stream_writer #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_last            (in_last),
    .in_ready           (in_ready),
    .ram1_write_en      (ram1_write_en),
    .ram1_write_address (ram1_write_address),
    .ram1_write_data    (ram1_write_data),
    .ram2_write_en      (ram2_write_en),
    .ram2_write_address (ram2_write_address),
    .ram2_write_data    (ram2_write_data),
    .bank_full          (bank_full),
    .bank_len0          (bank_len0),
    .bank_len1          (bank_len1),
    .bank_release       (bank_release),
    .release_err        (release_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 0;

  // Model state: what the DUT outputs must be after the upcoming edge.
  int         m_bank, m_addr;
  logic       m_ready, m_err;
  logic [1:0] m_full, m_wen;
  int         m_len   [2];
  int         m_waddr [2];
  int         m_wdata [2];

  // Expected outputs for the current cycle.
  logic       e_ready, e_err;
  logic [1:0] e_full, e_wen;
  int         e_len   [2];
  int         e_waddr [2];
  int         e_wdata [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model(input logic v, input logic [7:0] d, input logic l,
                       input logic [1:0] rel, input logic rst);
    bit acc;
    if (rst) begin
      m_bank = 0; m_addr = 0; m_ready = 0; m_err = 0; m_full = 0; m_wen = 0;
      for (int b = 0; b < 2; b++) begin
        m_len[b] = 0; m_waddr[b] = 0; m_wdata[b] = 0;
      end
      return;
    end
    acc   = v && m_ready;
    m_wen = 0;
    if (acc) begin
      m_wen[m_bank]   = 1'b1;
      m_waddr[m_bank] = m_addr;
      m_wdata[m_bank] = d;
    end
    for (int b = 0; b < 2; b++)
      if (rel[b]) begin
        if (m_full[b]) m_full[b] = 1'b0;
        else           m_err     = 1'b1;
      end
    if (acc) begin
      if (m_addr == 31 || l) begin
        m_full[m_bank] = 1'b1;
        m_len[m_bank]  = m_addr + 1;
        m_addr = 0;
        m_bank = 1 - m_bank;
      end else begin
        m_addr++;
      end
    end
    m_ready = !m_full[m_bank];
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic [1:0] rel, input logic rst);
    in_valid = v; in_data = d; in_last = l; bank_release = rel; reset = rst;
    model(v, d, l, rel, rst);
    @(posedge clk);
    e_ready = m_ready; e_err = m_err; e_full = m_full; e_wen = m_wen;
    for (int b = 0; b < 2; b++) begin
      e_len[b] = m_len[b]; e_waddr[b] = m_waddr[b]; e_wdata[b] = m_wdata[b];
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",   in_ready,           e_ready);
      chk("ram1_wen",   ram1_write_en,      e_wen[0]);
      chk("ram1_addr",  ram1_write_address, e_waddr[0]);
      chk("ram1_data",  ram1_write_data,    e_wdata[0]);
      chk("ram2_wen",   ram2_write_en,      e_wen[1]);
      chk("ram2_addr",  ram2_write_address, e_waddr[1]);
      chk("ram2_data",  ram2_write_data,    e_wdata[1]);
      chk("bank_full",  bank_full,          e_full);
      chk("bank_len0",  bank_len0,          e_len[0]);
      chk("bank_len1",  bank_len1,          e_len[1]);
      chk("release_err", release_err,       e_err);
    end
  end

  initial begin
    int vp, rp;
    logic [1:0] rel;
    in_valid = 0; in_data = 0; in_last = 0; bank_release = 0; reset = 1;
    @(posedge clk); #1;
    step(0, 0, 0, 2'b00, 1);
    chk_en = 1;
    chk("lit_reset_ready", in_ready, 1'b0);
    chk("lit_reset_full",  bank_full, 2'b00);
    step(0, 0, 0, 2'b00, 0);
    chk("lit_ready_after_reset", in_ready, 1'b1);

    // Full frame into bank 0
    for (int i = 0; i < 32; i++) step(1, 8'(i), 0, 2'b00, 0);
    chk("lit_full_frame_full", bank_full, 2'b01);
    chk("lit_full_frame_len0", bank_len0, 6'd32);
    step(1, 8'hA5, 0, 2'b00, 0);
    chk("lit_next_ram2_wen",  ram2_write_en, 1'b1);
    chk("lit_next_ram2_addr", ram2_write_address, 5'd0);
    chk("lit_next_ram2_data", ram2_write_data, 8'hA5);

    // Backpressure: complete bank 1 without release
    for (int i = 1; i < 32; i++) step(1, 8'(8'h20 + i), 0, 2'b00, 0);
    chk("lit_bp_full",  bank_full, 2'b11);
    chk("lit_bp_ready", in_ready, 1'b0);
    step(1, 8'h77, 0, 2'b00, 0);
    chk("lit_bp_no_write", ram1_write_en | ram2_write_en, 1'b0);
    step(0, 0, 0, 2'b01, 0);
    chk("lit_rel0_full",  bank_full, 2'b10);
    chk("lit_rel0_ready", in_ready, 1'b1);
    step(1, 8'h41, 0, 2'b00, 0);
    chk("lit_w65_wen",  ram1_write_en, 1'b1);
    chk("lit_w65_addr", ram1_write_address, 5'd0);

    // Close bank 0 while releasing bank 1
    for (int i = 1; i < 31; i++) step(1, 8'(i), 0, 2'b00, 0);
    step(1, 8'hEE, 0, 2'b10, 0);
    chk("lit_cr_full",  bank_full, 2'b01);
    chk("lit_cr_ready", in_ready, 1'b1);
    step(1, 8'h11, 0, 2'b00, 0);
    chk("lit_cr_ram2_wen",  ram2_write_en, 1'b1);
    chk("lit_cr_ram2_addr", ram2_write_address, 5'd0);

    // Short frame
    step(0, 0, 0, 2'b00, 1);
    step(0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), (i == 4), 2'b00, 0);
    chk("lit_short_full", bank_full, 2'b01);
    chk("lit_short_len0", bank_len0, 6'd5);
    step(1, 8'h60, 0, 2'b00, 0);
    chk("lit_short_ram2_wen",  ram2_write_en, 1'b1);
    chk("lit_short_ram2_addr", ram2_write_address, 5'd0);

    // Release error on the bank being filled
    step(0, 0, 0, 2'b10, 0);
    chk("lit_err_set", release_err, 1'b1);
    step(0, 0, 0, 2'b01, 0);
    chk("lit_err_full", bank_full, 2'b00);
    step(1, 8'h61, 1, 2'b00, 0);
    chk("lit_err_len1", bank_len1, 6'd2);
    for (int i = 0; i < 32; i++) step(1, 8'(8'h80 + i), 0, 2'b00, 0);
    chk("lit_len0_32",   bank_len0, 6'd32);
    chk("lit_err_stays", release_err, 1'b1);
    chk("lit_both_full", bank_full, 2'b11);

    // Reset mid-frame
    step(0, 0, 0, 2'b10, 0);
    for (int i = 0; i < 10; i++) step(1, 8'(i), 0, 2'b00, 0);
    chk("lit_mid_addr", ram2_write_address, 5'd9);
    step(1, 8'hFF, 0, 2'b00, 1);
    chk("lit_rst_full", bank_full, 2'b00);
    chk("lit_rst_len0", bank_len0, 6'd0);
    chk("lit_rst_len1", bank_len1, 6'd0);
    chk("lit_rst_err",  release_err, 1'b0);
    chk("lit_rst_wen",  ram1_write_en | ram2_write_en, 1'b0);
    step(0, 0, 0, 2'b00, 0);
    step(1, 8'h33, 0, 2'b00, 0);
    chk("lit_rst_w_wen",  ram1_write_en, 1'b1);
    chk("lit_rst_w_addr", ram1_write_address, 5'd0);

    // Random traffic with a mostly well-behaved reader
    for (int i = 0; i < 4000; i++) begin
      case (i / 1000)
        0:       begin vp = 90;  rp = 8;  end
        1:       begin vp = 50;  rp = 4;  end
        2:       begin vp = 100; rp = 40; end
        default: begin vp = 30;  rp = 2;  end
      endcase
      rel = 2'b00;
      for (int b = 0; b < 2; b++) begin
        if (m_full[b] && $urandom_range(rp - 1) == 0) rel[b] = 1'b1;
        if ($urandom_range(299) == 0) rel[b] = 1'b1;
      end
      step($urandom_range(99) < vp, 8'($urandom), $urandom_range(15) == 0,
           rel, $urandom_range(799) == 0);
    end

    step(0, 0, 0, 2'b00, 0);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
